// File: rtl/core_pkg.sv
// core_pkg: shared core types.
//   reg_idx_t        - architectural register index (x0..x31)
//   rd_src_e         - which unit produces an instruction's destination value
//   scoreboard_cnt_t - per-register pending-write counter at the default depth
package core_pkg;

  localparam int NUM_ARCH_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    RD_FROM_ALU      = 2'd0,
    RD_FROM_MEM_LOAD = 2'd1,
    RD_FROM_MUL      = 2'd2,
    RD_FROM_CSR      = 2'd3
  } rd_src_e;

  // Scoreboard defaults
  localparam int SB_MAX_PENDING = 3;
  localparam int SB_MAX_LOADS   = 4;
  localparam int SB_CNT_W       = $clog2(SB_MAX_PENDING + 1);

  typedef logic [SB_CNT_W-1:0] scoreboard_cnt_t;

endpackage

// File: rtl/core_scoreboard_popcnt.sv
// core_scoreboard_popcnt: counts how many writeback ports retire this cycle
// against one target.
//   i_valid    - per-port retire strobe
//   i_rd       - per-port retired destination
//   i_is_load  - per-port load flag
//   i_idx      - register to match (ignored when i_sel_load)
//   i_sel_load - 1: count valid load retires; 0: count valid retires to i_idx
//   o_cnt      - number of matching ports
module core_scoreboard_popcnt
  import core_pkg::*;
#(
  parameter int NUM_WB_PORTS = 2,
  parameter int CW           = $clog2(NUM_WB_PORTS + 1)
) (
  input  logic                        i_sel_load,
  input  logic [NUM_WB_PORTS-1:0]     i_valid,
  input  reg_idx_t [NUM_WB_PORTS-1:0] i_rd,
  input  logic [NUM_WB_PORTS-1:0]     i_is_load,
  input  reg_idx_t                    i_idx,
  output logic [CW-1:0]               o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (i_valid[p] && (i_sel_load ? i_is_load[p] : (i_rd[p] == i_idx)))
        o_cnt = o_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/core_scoreboard.sv
// core_scoreboard: register write-pending scoreboard.
// Tracks how many writes are in flight to each of x1..x31 and how many
// memory loads are in flight overall. Issue is throttled when a register's
// counter is full or the load budget is exhausted.
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_flush          - drop all in-flight tracking (underflow flag kept)
//   i_issue_*        - issue request (valid/rd/source); o_issue_ready accepts
//   i_wb_*           - per-port retire strobe/destination/load flag
//   i_rs_idx         - per-port source lookup; o_rs_busy reports pending
//   o_load_pending   - any load in flight
//   o_idle           - nothing in flight
//   o_underflow      - sticky: a retire had no matching pending write
module core_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WB_PORTS = 2,
  parameter int MAX_PENDING  = SB_MAX_PENDING,
  parameter int MAX_LOADS    = SB_MAX_LOADS
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_flush,
  input  logic                        i_issue_valid,
  input  reg_idx_t                    i_issue_rd,
  input  rd_src_e                     i_issue_rd_src,
  output logic                        o_issue_ready,
  input  logic [NUM_WB_PORTS-1:0]     i_wb_valid,
  input  reg_idx_t [NUM_WB_PORTS-1:0] i_wb_rd,
  input  logic [NUM_WB_PORTS-1:0]     i_wb_is_load,
  input  reg_idx_t [NUM_RD_PORTS-1:0] i_rs_idx,
  output logic [NUM_RD_PORTS-1:0]     o_rs_busy,
  output logic                        o_load_pending,
  output logic                        o_idle,
  output logic                        o_underflow
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int LD_W  = $clog2(MAX_LOADS + 1);
  localparam int RET_W = $clog2(NUM_WB_PORTS + 1);

  // Registered state; x0 has no counter.
  logic [31:1][CNT_W-1:0] r_cnt;
  logic [LD_W-1:0]        r_loads;
  logic                   r_underflow;

  // Combinational next state
  logic [31:1][RET_W-1:0] w_ret;
  logic [RET_W-1:0]       w_load_ret;
  logic [31:1][CNT_W-1:0] w_next;
  logic [LD_W-1:0]        w_next_loads;
  logic                   w_uflow;
  logic                   w_fire;
  logic                   w_load_fire;
  logic [31:0][CNT_W-1:0] w_cnt_full;
  logic                   w_rd_full;
  logic                   w_loads_full;

  // Per-register retire counters
  for (genvar g = 1; g < 32; g++) begin : g_reg_pop
    core_scoreboard_popcnt #(
      .NUM_WB_PORTS (NUM_WB_PORTS),
      .CW           (RET_W)
    ) u_pop (
      .i_sel_load (1'b0),
      .i_valid    (i_wb_valid),
      .i_rd       (i_wb_rd),
      .i_is_load  (i_wb_is_load),
      .i_idx      (5'(g)),
      .o_cnt      (w_ret[g])
    );
  end

  // Load retire counter
  core_scoreboard_popcnt #(
    .NUM_WB_PORTS (NUM_WB_PORTS),
    .CW           (RET_W)
  ) u_load_pop (
    .i_sel_load (1'b1),
    .i_valid    (i_wb_valid),
    .i_rd       (i_wb_rd),
    .i_is_load  (i_wb_is_load),
    .i_idx      ('0),
    .o_cnt      (w_load_ret)
  );

  // Slot 0 reads as an always-empty counter so x0 lookups are never busy.
  assign w_cnt_full = {r_cnt, CNT_W'(0)};

  // Ready looks only at registered state: a same-cycle retire never opens it.
  assign w_rd_full    = (i_issue_rd != '0) &&
                        (w_cnt_full[i_issue_rd] == CNT_W'(MAX_PENDING));
  assign w_loads_full = (i_issue_rd_src == RD_FROM_MEM_LOAD) &&
                        (r_loads == LD_W'(MAX_LOADS));
  assign o_issue_ready = !w_rd_full && !w_loads_full;

  assign w_fire      = i_issue_valid && o_issue_ready;
  assign w_load_fire = w_fire && (i_issue_rd_src == RD_FROM_MEM_LOAD);

  // next = count + fire - retires, clamped at zero with underflow raised.
  // Fire is blocked at MAX, so the sum never exceeds the counter range.
  always_comb begin
    int s;
    w_uflow      = 1'b0;
    w_next       = '0;
    w_next_loads = '0;
    for (int r = 1; r < 32; r++) begin
      s = int'(r_cnt[r]) + ((w_fire && (i_issue_rd == 5'(r))) ? 1 : 0)
          - int'(w_ret[r]);
      if (s < 0) begin
        w_uflow   = 1'b1;
        w_next[r] = '0;
      end else begin
        w_next[r] = CNT_W'(s);
      end
    end
    s = int'(r_loads) + (w_load_fire ? 1 : 0) - int'(w_load_ret);
    if (s < 0) begin
      w_uflow      = 1'b1;
      w_next_loads = '0;
    end else begin
      w_next_loads = LD_W'(s);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_loads     <= '0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      // Flush discards the whole cycle's activity but keeps the error flag.
      r_cnt   <= '0;
      r_loads <= '0;
    end else begin
      r_cnt   <= w_next;
      r_loads <= w_next_loads;
      if (w_uflow) r_underflow <= 1'b1;
    end
  end

  always_comb begin
    o_rs_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++)
      o_rs_busy[p] = (w_cnt_full[i_rs_idx[p]] != '0);
  end

  assign o_load_pending = (r_loads != '0);
  assign o_idle         = (r_cnt == '0) && (r_loads == '0);
  assign o_underflow    = r_underflow;

endmodule

// File: doc/core_scoreboard.md
CORE_SCOREBOARD -- requirements
Module: core_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD_PORTS, default 2, meaning the number of source-register busy lookups.
REQ-002 SHALL have parameter NUM_WB_PORTS, default 2, meaning the number of independent writeback retire ports.
REQ-003 SHALL have parameter MAX_PENDING, default 3, meaning the maximum number of in-flight writes per register (range 1..15).
REQ-004 SHALL have parameter MAX_LOADS, default 4, meaning the maximum number of in-flight RD_FROM_MEM_LOAD writes in total.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_flush, input, 1 bit: discard all in-flight tracking.
REQ-008 SHALL have port i_issue_valid, input, 1 bit: an instruction requests issue.
REQ-009 SHALL have port i_issue_rd, input, reg_idx_t: destination register of the issuing instruction.
REQ-010 SHALL have port i_issue_rd_src, input, rd_src_e: writeback source of the issuing instruction.
REQ-011 SHALL have port o_issue_ready, output, 1 bit: the issue is accepted this cycle when high together with i_issue_valid.
REQ-012 SHALL have port i_wb_valid, input, NUM_WB_PORTS bits: per-port retire strobe.
REQ-013 SHALL have port i_wb_rd, input, NUM_WB_PORTS x reg_idx_t: per-port retired destination.
REQ-014 SHALL have port i_wb_is_load, input, NUM_WB_PORTS bits: per-port flag marking a memory-load retire.
REQ-015 SHALL have port i_rs_idx, input, NUM_RD_PORTS x reg_idx_t: per-port lookup index.
REQ-016 SHALL have port o_rs_busy, output, NUM_RD_PORTS bits: per-port flag, high when the looked-up register has a pending write.
REQ-017 SHALL have port o_load_pending, output, 1 bit: high when any load is in flight.
REQ-018 SHALL have port o_idle, output, 1 bit: high when nothing at all is in flight.
REQ-019 SHALL have port o_underflow, output, 1 bit: sticky error flag for a retire with no matching pending write.

Function
REQ-020 SHALL hold one pending counter per register x1..x31, each $clog2(MAX_PENDING+1) bits wide.
REQ-021 SHALL never track x0: issue to x0 always fires without counting, retire to x0 is ignored, and a lookup of x0 always reports not busy.
REQ-022 SHALL accept an issue (fire) when i_issue_valid and o_issue_ready are both high.
REQ-023 SHALL drive o_issue_ready low if counter[rd]==MAX_PENDING, or if the issue is a load (RD_FROM_MEM_LOAD) and the load counter==MAX_LOADS.
REQ-024 SHALL compute o_issue_ready from registered state only, so a same-cycle retire does not raise ready.
REQ-025 SHALL update each register as next = counter + fire_to_rd − (number of valid retires to that register across all ports), all in the same cycle.
REQ-026 SHALL give an issue and a retire to the same register in the same cycle a net change of zero.
REQ-027 SHALL saturate a counter at 0 when retires exceed counter+fire, and SHALL then set o_underflow.
REQ-028 SHALL update the load counter as next = loads + load_fire − popcount(i_wb_valid & i_wb_is_load), with the same zero-saturation and o_underflow rule.
REQ-029 SHALL drive o_rs_busy[p] as (counter[i_rs_idx[p]] != 0), combinational from registered state, with no bypass.
REQ-030 SHALL make an issue fired at edge N visible on o_rs_busy from cycle N+1 onward.
REQ-031 SHALL make a retire at edge N clear busy from cycle N+1 onward.
REQ-032 SHALL, on i_flush, zero all counters and the load counter at the next edge, and SHALL ignore any issue or retires in that cycle.
REQ-033 SHALL let flush take priority over all other updates.
REQ-034 SHALL leave o_underflow unchanged on flush.
REQ-035 SHALL drive o_load_pending as (load counter != 0).
REQ-036 SHALL drive o_idle high when all counters and the load counter are zero.

Reset
REQ-037 SHALL, on i_rst at a rising edge, zero all counters, zero the load counter and clear o_underflow.
REQ-038 SHALL give reset priority over flush, issue and retire.
REQ-039 SHALL produce these values after reset: o_issue_ready=1, o_rs_busy=0, o_load_pending=0, o_idle=1, o_underflow=0.

Structure
REQ-040 SHALL take reg_idx_t and rd_src_e from core_pkg.
REQ-041 SHALL add scoreboard_cnt_t and the MAX_PENDING/MAX_LOADS defaults to core_pkg.
REQ-042 SHALL use one sub-module, core_scoreboard_popcnt, which counts the valid retires matching a given index or the load flag.

Verification
REQ-043 SHALL verify basic tracking: issue rd=5 (ALU) in cycle 0 -> o_rs_busy=1 for rs=5 in cycle 1; retire wb0 rd=5 in cycle 3 -> busy=0 in cycle 4 and o_idle=1.
REQ-044 SHALL verify per-register saturation: with MAX_PENDING=3, issue rd=7 three times -> o_issue_ready=0 while rd=7 is presented; present rd=8 -> o_issue_ready=1.
REQ-045 SHALL verify simultaneous events: counter[9]=2, then a same-cycle issue rd=9 plus retires on wb0 and wb1 to rd=9 -> counter[9]=1 and busy remains 1.
REQ-046 SHALL verify load limiting: with MAX_LOADS=4, four load issues -> o_load_pending=1 and load issue ready=0 while an ALU issue is still ready; one load retire -> load ready=1 next cycle.
REQ-047 SHALL verify flush and x0: flush with registers 3, 4, 5 pending plus a same-cycle issue rd=6 -> all busy=0 and o_idle=1 next cycle; issue rd=0 -> busy(x0)=0.
REQ-048 SHALL verify underflow: retire rd=12 with counter[12]=0 -> o_underflow=1 stays set through a flush and clears only on i_rst.
